// File: rtl/nios2system_pio_poller.sv
// Purpose: Avalon-MM read-only master that periodically polls a PIO data register and reports value/edge changes.
// Latency: read issued after POLL_PERIOD enabled idle cycles; outputs update the cycle after the CAPTURE cycle.
// Backpressure: avm_waitrequest stalls the READ state with address/read held stable; no other flow control.
module nios2system_pio_poller #(
    parameter int ADDR_W      = 2,
    parameter int DATA_W      = 4,
    parameter int POLL_ADDR   = 0,
    parameter int POLL_PERIOD = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic [DATA_W-1:0] value_out,
    output logic              valid,
    output logic              changed,
    output logic [DATA_W-1:0] rise,
    output logic [DATA_W-1:0] fall
);

    // Counter only needs to reach POLL_PERIOD-1; keep at least one bit for POLL_PERIOD=1.
    localparam int CNT_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  counter;
    logic              enable_q;
    logic [DATA_W-1:0] sample;

    // The polled register never moves, so the address is a constant in every state.
    assign avm_address = ADDR_W'(POLL_ADDR);

    // Only the low DATA_W bits of the slave data are meaningful.
    assign sample = avm_readdata[DATA_W-1:0];

    // Upper readdata bits are deliberately ignored; fold them into a sink so they are visibly unused.
    generate
        if (DATA_W < 32) begin : g_unused_hi
            logic unused_readdata_hi;
            assign unused_readdata_hi = &{1'b0, avm_readdata[31:DATA_W]};
        end
    endgenerate

    // Poll sequencer: counts enabled idle cycles, runs one read, captures and derives change/edge pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            counter   <= '0;
            enable_q  <= 1'b0;
            avm_read  <= 1'b0;
            value_out <= '0;
            valid     <= 1'b0;
            changed   <= 1'b0;
            rise      <= '0;
            fall      <= '0;
        end else begin
            enable_q <= enable;
            // Pulses are single-cycle; only the CAPTURE branch can raise them.
            changed  <= 1'b0;
            rise     <= '0;
            fall     <= '0;

            case (state)
                IDLE: begin
                    avm_read <= 1'b0;
                    if (!enable) begin
                        counter <= '0;
                    end else if (counter == CNT_LAST) begin
                        // A freshly raised enable never launches a read on its first cycle;
                        // this only matters when POLL_PERIOD is 1 and the counter sits at its end value.
                        if (enable_q) begin
                            state    <= READ;
                            avm_read <= 1'b1;
                            counter  <= '0;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end

                READ: begin
                    // Transfer runs to completion regardless of enable.
                    if (!avm_waitrequest) begin
                        state    <= CAPTURE;
                        avm_read <= 1'b0;
                    end
                end

                CAPTURE: begin
                    // Fixed read latency of one: readdata is valid in this cycle.
                    avm_read  <= 1'b0;
                    value_out <= sample;
                    valid     <= 1'b1;
                    if (valid) begin
                        changed <= (sample != value_out);
                        rise    <= sample & ~value_out;
                        fall    <= ~sample & value_out;
                    end
                    state   <= IDLE;
                    counter <= '0;
                end

                default: begin
                    state    <= IDLE;
                    avm_read <= 1'b0;
                    counter  <= '0;
                end
            endcase
        end
    end

endmodule
